// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode constants and field layout for the instruction word format.
// The decoder uses the same constants, so the loader and decoder stay in step.
package instr_encoder_loader_pkg;

   // Field widths of the 32-bit instruction word
   localparam int OP_W  = 5;
   localparam int REG_W = 5;
   localparam int IMM_W = 17;
   localparam int TGT_W = 27;

   // Opcodes
   localparam logic [OP_W-1:0] OP_R    = 5'd0;
   localparam logic [OP_W-1:0] OP_J    = 5'd1;
   localparam logic [OP_W-1:0] OP_BNE  = 5'd2;
   localparam logic [OP_W-1:0] OP_JAL  = 5'd3;
   localparam logic [OP_W-1:0] OP_JR   = 5'd4;
   localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
   localparam logic [OP_W-1:0] OP_BLT  = 5'd6;
   localparam logic [OP_W-1:0] OP_SW   = 5'd7;
   localparam logic [OP_W-1:0] OP_LW   = 5'd8;
   localparam logic [OP_W-1:0] OP_SETX = 5'd21;
   localparam logic [OP_W-1:0] OP_BEX  = 5'd22;

   // Field-level instruction request
   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] shamt;
      logic [REG_W-1:0] aluop;
      logic [IMM_W-1:0] imm;
      logic [TGT_W-1:0] target;
   } instr_fields_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: opcode + operand fields -> 32-bit word and legality flag.
module instr_pack
   import instr_encoder_loader_pkg::*;
(
   input  instr_fields_t fields,
   output logic [31:0]   word,
   output logic          legal
);

   // Select the word layout by instruction class; unknown opcodes are flagged illegal
   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (fields.opcode)
         OP_R: begin
            word  = {fields.opcode, fields.rd, fields.rs, fields.rt,
                     fields.shamt, fields.aluop, 2'b00};
            legal = 1'b1;
         end
         OP_J, OP_JAL, OP_SETX, OP_BEX: begin
            word  = {fields.opcode, fields.target};
            legal = 1'b1;
         end
         OP_JR: begin
            word  = {fields.opcode, fields.rd, 22'b0};
            legal = 1'b1;
         end
         OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: begin
            word  = {fields.opcode, fields.rd, fields.rs, fields.imm};
            legal = 1'b1;
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field-level requests, packs them and writes them to
// consecutive imem addresses starting at a per-session base address.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs,
   input  logic [4:0]            in_rt,
   input  logic [4:0]            in_shamt,
   input  logic [4:0]            in_aluop,
   input  logic [16:0]           in_imm,
   input  logic [26:0]           in_target,
   input  logic                  in_last,
   output logic                  imem_wren,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  err_illegal,
   output logic                  err_overflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr_ptr;
   logic                  full;      // last address has already been written
   logic                  accept;
   instr_fields_t         fields;
   logic [31:0]           packed_word;
   logic                  packed_legal;

   // Gather the request fields for the packer
   always_comb begin
      fields.opcode = in_opcode;
      fields.rd     = in_rd;
      fields.rs     = in_rs;
      fields.rt     = in_rt;
      fields.shamt  = in_shamt;
      fields.aluop  = in_aluop;
      fields.imm    = in_imm;
      fields.target = in_target;
   end

   instr_pack u_pack (
      .fields (fields),
      .word   (packed_word),
      .legal  (packed_legal)
   );

   assign in_ready = (state == S_RUN);
   assign accept   = in_valid & in_ready;

   // Session FSM, address counter and registered imem/status outputs.
   // addr_ptr wraps after the top address, so a separate full flag remembers
   // that the top address was used and the next legal request must overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         addr_ptr     <= '0;
         full         <= 1'b0;
         imem_wren    <= 1'b0;
         imem_addr    <= '0;
         imem_data    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         word_count   <= '0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         imem_wren <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_RUN;
                  busy         <= 1'b1;
                  addr_ptr     <= base_addr;
                  full         <= 1'b0;
                  word_count   <= '0;
                  err_illegal  <= 1'b0;
                  err_overflow <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (!packed_legal) begin
                     err_illegal <= 1'b1;
                     if (in_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else if (full) begin
                     err_overflow <= 1'b1;
                     state        <= S_DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                  end else begin
                     imem_wren  <= 1'b1;
                     imem_addr  <= addr_ptr;
                     imem_data  <= packed_word;
                     addr_ptr   <= addr_ptr + 1'b1;
                     word_count <= word_count + 1'b1;
                     if (addr_ptr == '1) full <= 1'b1;
                     if (in_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encoding table,
// hand-written session sequences and randomized sessions against a model.
module tb_instr_encoder_loader;

   localparam int AW  = 12;
   localparam int TOP = (1 << AW) - 1;

   logic          clock = 1'b0;
   logic          reset, start, in_valid, in_ready, in_last;
   logic [AW-1:0] base_addr;
   logic [4:0]    in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
   logic [16:0]   in_imm;
   logic [26:0]   in_target;
   logic          imem_wren, busy, done, err_illegal, err_overflow;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic [AW:0]   word_count;

   int checks   = 0;
   int failures = 0;

   // Model state for the current session
   int m_ptr, m_count;
   bit m_full, m_ill, m_ovf, m_ended;

   instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
      .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
      .in_last(in_last), .imem_wren(imem_wren), .imem_addr(imem_addr),
      .imem_data(imem_data), .busy(busy), .done(done), .word_count(word_count),
      .err_illegal(err_illegal), .err_overflow(err_overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference encoder from the instruction-format rules, plain arithmetic
   function automatic logic [32:0] ref_encode(input int op, input int rd, input int rs,
                                              input int rt, input int sh, input int al,
                                              input int imm, input int tgt);
      longint w;
      if (op == 0)
         w = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs) * 131072
             + longint'(rt) * 4096 + longint'(sh) * 128 + longint'(al) * 4;
      else if (op == 1 || op == 3 || op == 21 || op == 22)
         w = longint'(op) * 134217728 + longint'(tgt);
      else if (op == 4)
         w = longint'(op) * 134217728 + longint'(rd) * 4194304;
      else if (op == 2 || (op >= 5 && op <= 8))
         w = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs) * 131072
             + longint'(imm);
      else
         return {1'b0, 32'h0};
      return {1'b1, w[31:0]};
   endfunction

   task automatic idle_inputs();
      start = 0; in_valid = 0; in_last = 0;
      in_opcode = 0; in_rd = 0; in_rs = 0; in_rt = 0; in_shamt = 0; in_aluop = 0;
      in_imm = 0; in_target = 0;
   endtask

   task automatic begin_session(input int base);
      base_addr = base[AW-1:0];
      start = 1;
      tick();
      start = 0;
      m_ptr = base; m_count = 0; m_full = 0; m_ill = 0; m_ovf = 0; m_ended = 0;
      chk("busy_after_start", busy, 1);
      chk("ready_after_start", in_ready, 1);
      chk("count_after_start", word_count, 0);
      chk("errs_after_start", {err_illegal, err_overflow}, 0);
   endtask

   // Apply one request in RUN and check the cycle that follows against the model
   task automatic req(input int op, input int rd, input int rs, input int rt, input int sh,
                      input int al, input int imm, input int tgt, input bit last);
      logic [32:0] r;
      bit          ew;
      int          ea;
      r = ref_encode(op, rd, rs, rt, sh, al, imm, tgt);
      in_opcode = op[4:0]; in_rd = rd[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0];
      in_shamt = sh[4:0]; in_aluop = al[4:0]; in_imm = imm[16:0]; in_target = tgt[26:0];
      in_last = last; in_valid = 1;
      tick();
      in_valid = 0; in_last = 0;
      ew = 0; ea = 0;
      if (!r[32]) begin
         m_ill = 1;
         if (last) m_ended = 1;
      end else if (m_full) begin
         m_ovf = 1; m_ended = 1;
      end else begin
         ew = 1; ea = m_ptr;
         if (m_ptr == TOP) m_full = 1;
         m_ptr = (m_ptr + 1) % (TOP + 1);
         m_count++;
         if (last) m_ended = 1;
      end
      chk("wren", imem_wren, ew);
      if (ew) begin
         chk("addr", imem_addr, ea);
         chk("data", imem_data, r[31:0]);
      end
      chk("done", done, m_ended);
      chk("busy", busy, !m_ended);
      chk("ready", in_ready, !m_ended);
      chk("word_count", word_count, m_count);
      chk("err_illegal", err_illegal, m_ill);
      chk("err_overflow", err_overflow, m_ovf);
   endtask

   task automatic finish_session();
      tick();
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", in_ready, 0);
      chk("idle_count_held", word_count, m_count);
   endtask

   typedef struct {
      int          op, rd, rs, rt, sh, al, imm, tgt;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vec_t v;
      int   legal_ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};

      idle_inputs();
      base_addr = '0;
      reset = 1;
      tick(); tick();
      chk("rst_wren", imem_wren, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_data", imem_data, 0);
      chk("rst_flags", {in_ready, busy, done, err_illegal, err_overflow}, 0);
      chk("rst_count", word_count, 0);
      reset = 0;
      tick();
      chk("idle_ready", in_ready, 0);

      // Directed encoding table: {op, rd, rs, rt, shamt, aluop, imm, target, legal, word}
      vecs.push_back('{0, 3, 2, 2, 0, 0, 0, 0, 1'b1, 32'h00C42000});
      vecs.push_back('{5, 1, 0, 0, 0, 0, 5, 0, 1'b1, 32'h28400005});
      vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 'h10, 1'b1, 32'h08000010});
      vecs.push_back('{7, 2, 1, 0, 0, 0, 3, 0, 1'b1, 32'h38820003});
      vecs.push_back('{3, 0, 0, 0, 0, 0, 0, 'h1234, 1'b1, 32'h18001234});
      vecs.push_back('{4, 31, 7, 9, 0, 0, 'h55, 'h77, 1'b1, 32'h27C00000});
      vecs.push_back('{0, 31, 31, 31, 31, 31, 0, 0, 1'b1, 32'h07FFFFFC});
      vecs.push_back('{8, 0, 31, 0, 0, 0, 'h1FFFF, 0, 1'b1, 32'h403FFFFF});
      vecs.push_back('{22, 0, 0, 0, 0, 0, 0, 'h7FFFFFF, 1'b1, 32'hB7FFFFFF});
      vecs.push_back('{21, 0, 0, 0, 0, 0, 0, 'h5A5A5A5, 1'b1, 32'hADA5A5A5});
      vecs.push_back('{9, 1, 1, 1, 1, 1, 1, 1, 1'b0, 32'h0});
      vecs.push_back('{31, 1, 1, 1, 1, 1, 1, 1, 1'b0, 32'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         base_addr = AW'(16 + i);
         start = 1; tick(); start = 0;
         in_opcode = v.op[4:0]; in_rd = v.rd[4:0]; in_rs = v.rs[4:0]; in_rt = v.rt[4:0];
         in_shamt = v.sh[4:0]; in_aluop = v.al[4:0]; in_imm = v.imm[16:0];
         in_target = v.tgt[26:0]; in_last = 1; in_valid = 1;
         tick();
         in_valid = 0; in_last = 0;
         chk("tbl_wren", imem_wren, v.legal);
         if (v.legal) begin
            chk("tbl_addr", imem_addr, 16 + i);
            chk("tbl_data", imem_data, v.word);
         end
         chk("tbl_illegal", err_illegal, !v.legal);
         chk("tbl_done", done, 1);
         chk("tbl_count", word_count, v.legal ? 1 : 0);
         tick();
         chk("tbl_done_drop", done, 0);
      end

      // Back-to-back addi, j, sw from address 0
      begin_session(0);
      req(5, 1, 0, 0, 0, 0, 5, 0, 0);
      chk("b2b_word0", imem_data, 32'h28400005);
      req(1, 0, 0, 0, 0, 0, 0, 'h10, 0);
      chk("b2b_word1", imem_data, 32'h08000010);
      req(7, 2, 1, 0, 0, 0, 3, 0, 1);
      chk("b2b_word2", imem_data, 32'h38820003);
      chk("b2b_addr2", imem_addr, 2);
      finish_session();

      // Illegal opcode between two legal requests
      begin_session('h100);
      req(5, 1, 0, 0, 0, 0, 5, 0, 0);
      req(9, 3, 3, 3, 3, 3, 3, 3, 0);
      req(7, 2, 1, 0, 0, 0, 3, 0, 1);
      chk("ill_next_addr", imem_addr, 'h101);
      finish_session();

      // Overflow at the top of imem
      begin_session('hFFE);
      req(5, 1, 0, 0, 0, 0, 5, 0, 0);
      req(5, 2, 0, 0, 0, 0, 6, 0, 0);
      chk("ovf_top_addr", imem_addr, 'hFFF);
      req(5, 3, 0, 0, 0, 0, 7, 0, 1);
      chk("ovf_flag", err_overflow, 1);
      chk("ovf_no_write", imem_wren, 0);
      finish_session();

      // Reset in the cycle after an accept, with a new request pending
      begin_session('h20);
      req(5, 1, 0, 0, 0, 0, 5, 0, 0);
      in_opcode = 5'd5; in_valid = 1; reset = 1;
      tick();
      in_valid = 0; reset = 0;
      chk("rst_mid_wren", imem_wren, 0);
      chk("rst_mid_addr", imem_addr, 0);
      chk("rst_mid_data", imem_data, 0);
      chk("rst_mid_flags", {in_ready, busy, done, err_illegal, err_overflow}, 0);
      chk("rst_mid_count", word_count, 0);
      tick();
      chk("rst_mid_idle", {in_ready, imem_wren}, 0);

      // Reset on the same edge as an accept: the write must not happen
      begin_session('h30);
      in_opcode = 5'd5; in_valid = 1; reset = 1;
      tick();
      in_valid = 0; reset = 0;
      chk("rst_acc_wren", imem_wren, 0);
      chk("rst_acc_busy", busy, 0);

      // Randomized sessions, with stray start pulses during RUN
      for (int s = 0; s < 30; s++) begin
         int base, n;
         base = ($urandom_range(0, 3) == 0) ? TOP - int'($urandom_range(0, 5))
                                            : int'($urandom_range(0, TOP));
         n = $urandom_range(1, 12);
         begin_session(base);
         for (int k = 0; k < n && !m_ended; k++) begin
            int op;
            while ($urandom_range(0, 3) == 0) begin
               start = $urandom_range(0, 1);
               base_addr = AW'($urandom);
               tick();
               start = 0;
               chk("gap_wren", imem_wren, 0);
               chk("gap_busy", busy, 1);
            end
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31))
                                             : legal_ops[$urandom_range(0, 10)];
            req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 'h1FFFF),
                int'($urandom & 32'h07FFFFFF), k == n - 1);
         end
         finish_session();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
